// File: rtl/wb_stage_controller.sv
// Writeback-stage controller: registers the writeback select, ALU source and
// destination register, and holds the pipeline while a load is outstanding.
module wb_stage_controller #(
   parameter int LOAD_TIMEOUT = 16
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       issue_valid_in,
   output logic       issue_ready_out,
   input  logic [2:0] wb_sel_in,
   input  logic       alu_src_in,
   input  logic [4:0] rd_addr_in,
   input  logic       rf_wr_en_in,
   input  logic       dmem_valid_in,
   input  logic       flush_in,
   output logic [2:0] wb_mux_sel_reg_out,
   output logic       alu_src_reg_out,
   output logic [4:0] rd_addr_reg_out,
   output logic       rf_wr_en_out,
   output logic       stall_out,
   output logic       load_fault_out
);

   localparam int CNT_W = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);
   localparam logic [2:0] SEL_ALU = 3'b000;
   localparam logic [2:0] SEL_LU  = 3'b001;

   typedef enum logic {
      S_IDLE,
      S_WAIT_LOAD
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [2:0]       r_sel;
   logic             r_alu_src;
   logic [4:0]       r_rd;
   logic             r_wr_en_cap;
   logic             r_wr_pulse;
   logic             r_fault;
   logic             w_wr_nxt;
   logic             w_fault_nxt;
   logic             w_accept;
   logic [2:0]       w_sel_norm;

   assign issue_ready_out    = (r_state == S_IDLE) && !rst_in && !flush_in;
   assign stall_out          = (r_state == S_WAIT_LOAD);
   assign w_accept           = issue_valid_in && issue_ready_out;
   assign wb_mux_sel_reg_out = r_sel;
   assign alu_src_reg_out    = r_alu_src;
   assign rd_addr_reg_out    = r_rd;
   assign rf_wr_en_out       = r_wr_pulse;
   assign load_fault_out     = r_fault;

   // Unused select codes collapse to the ALU source
   always_comb begin
      w_sel_norm = wb_sel_in;
      if (wb_sel_in == 3'b100 || wb_sel_in == 3'b110 || wb_sel_in == 3'b111)
         w_sel_norm = SEL_ALU;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_wr_nxt    = 1'b0;
      w_fault_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_sel_norm == SEL_LU) begin
                  w_state_nxt = S_WAIT_LOAD;
                  w_cnt_nxt   = '0;
               end else begin
                  w_wr_nxt = rf_wr_en_in && (rd_addr_in != 5'd0);
               end
            end
         end
         S_WAIT_LOAD: begin
            if (flush_in) begin
               w_state_nxt = S_IDLE;
            end else if (dmem_valid_in) begin
               // Data arriving on the last wait cycle still beats the timeout
               w_state_nxt = S_IDLE;
               w_wr_nxt    = r_wr_en_cap && (r_rd != 5'd0);
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = S_IDLE;
               w_fault_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_sel       <= SEL_ALU;
         r_alu_src   <= 1'b0;
         r_rd        <= 5'd0;
         r_wr_en_cap <= 1'b0;
         r_wr_pulse  <= 1'b0;
         r_fault     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_sel       <= w_sel_norm;
            r_alu_src   <= alu_src_in;
            r_rd        <= rd_addr_in;
            r_wr_en_cap <= rf_wr_en_in;
         end
         r_wr_pulse <= w_wr_nxt;
         r_fault    <= w_fault_nxt;
      end
   end

endmodule

// File: tb/tb_wb_stage_controller.sv
// Directed bench for wb_stage_controller: back-to-back writes, load wait,
// timeout, flush, select remapping and reset during a load.
module tb_wb_stage_controller;

   logic       clk_in = 1'b0;
   logic       rst_in;
   logic       issue_valid_in;
   logic       issue_ready_out;
   logic [2:0] wb_sel_in;
   logic       alu_src_in;
   logic [4:0] rd_addr_in;
   logic       rf_wr_en_in;
   logic       dmem_valid_in;
   logic       flush_in;
   logic [2:0] wb_mux_sel_reg_out;
   logic       alu_src_reg_out;
   logic [4:0] rd_addr_reg_out;
   logic       rf_wr_en_out;
   logic       stall_out;
   logic       load_fault_out;

   int errors = 0;
   int checks = 0;

   wb_stage_controller #(.LOAD_TIMEOUT(16)) dut (
      .clk_in             (clk_in),
      .rst_in             (rst_in),
      .issue_valid_in     (issue_valid_in),
      .issue_ready_out    (issue_ready_out),
      .wb_sel_in          (wb_sel_in),
      .alu_src_in         (alu_src_in),
      .rd_addr_in         (rd_addr_in),
      .rf_wr_en_in        (rf_wr_en_in),
      .dmem_valid_in      (dmem_valid_in),
      .flush_in           (flush_in),
      .wb_mux_sel_reg_out (wb_mux_sel_reg_out),
      .alu_src_reg_out    (alu_src_reg_out),
      .rd_addr_reg_out    (rd_addr_reg_out),
      .rf_wr_en_out       (rf_wr_en_out),
      .stall_out          (stall_out),
      .load_fault_out     (load_fault_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic req(input logic v, input logic [2:0] sel, input logic alu,
                      input logic [4:0] rd, input logic wr);
      issue_valid_in = v;
      wb_sel_in      = sel;
      alu_src_in     = alu;
      rd_addr_in     = rd;
      rf_wr_en_in    = wr;
   endtask

   initial begin
      rst_in = 1'b1;
      dmem_valid_in = 1'b0;
      flush_in = 1'b0;
      req(1'b0, 3'b000, 1'b0, 5'd0, 1'b0);
      step();
      step();
      check("rst_sel", 8'(wb_mux_sel_reg_out), 8'h0);
      check("rst_alu", 8'(alu_src_reg_out), 8'h0);
      check("rst_rd", 8'(rd_addr_reg_out), 8'h0);
      check("rst_wr", 8'(rf_wr_en_out), 8'h0);
      check("rst_fault", 8'(load_fault_out), 8'h0);
      check("rst_stall", 8'(stall_out), 8'h0);
      check("rst_ready", 8'(issue_ready_out), 8'h0);
      rst_in = 1'b0;
      #1;
      check("ready_after_rst", 8'(issue_ready_out), 8'h1);

      // Back-to-back ALU then IMM
      req(1'b1, 3'b000, 1'b1, 5'd5, 1'b1);
      step();
      check("b2b1_wr", 8'(rf_wr_en_out), 8'h1);
      check("b2b1_sel", 8'(wb_mux_sel_reg_out), 8'h0);
      check("b2b1_rd", 8'(rd_addr_reg_out), 8'd5);
      check("b2b1_alu", 8'(alu_src_reg_out), 8'h1);
      check("b2b1_stall", 8'(stall_out), 8'h0);
      req(1'b1, 3'b010, 1'b0, 5'd6, 1'b1);
      step();
      check("b2b2_wr", 8'(rf_wr_en_out), 8'h1);
      check("b2b2_sel", 8'(wb_mux_sel_reg_out), 8'h2);
      check("b2b2_rd", 8'(rd_addr_reg_out), 8'd6);
      check("b2b2_alu", 8'(alu_src_reg_out), 8'h0);
      check("b2b2_stall", 8'(stall_out), 8'h0);
      req(1'b0, 3'b011, 1'b1, 5'd9, 1'b1);
      step();
      check("hold_wr", 8'(rf_wr_en_out), 8'h0);
      check("hold_sel", 8'(wb_mux_sel_reg_out), 8'h2);
      check("hold_rd", 8'(rd_addr_reg_out), 8'd6);

      // dmem_valid ignored in IDLE
      dmem_valid_in = 1'b1;
      step();
      check("idle_dmem_wr", 8'(rf_wr_en_out), 8'h0);
      check("idle_dmem_stall", 8'(stall_out), 8'h0);
      dmem_valid_in = 1'b0;

      // Load, data on 3rd wait cycle
      req(1'b1, 3'b001, 1'b0, 5'd7, 1'b1);
      step();
      req(1'b0, 3'b000, 1'b0, 5'd0, 1'b0);
      check("ld_w1_stall", 8'(stall_out), 8'h1);
      check("ld_w1_wr", 8'(rf_wr_en_out), 8'h0);
      check("ld_w1_ready", 8'(issue_ready_out), 8'h0);
      check("ld_w1_sel", 8'(wb_mux_sel_reg_out), 8'h1);
      step();
      check("ld_w2_stall", 8'(stall_out), 8'h1);
      step();
      check("ld_w3_stall", 8'(stall_out), 8'h1);
      dmem_valid_in = 1'b1;
      step();
      dmem_valid_in = 1'b0;
      check("ld_done_stall", 8'(stall_out), 8'h0);
      check("ld_done_wr", 8'(rf_wr_en_out), 8'h1);
      check("ld_done_sel", 8'(wb_mux_sel_reg_out), 8'h1);
      check("ld_done_rd", 8'(rd_addr_reg_out), 8'd7);
      check("ld_done_ready", 8'(issue_ready_out), 8'h1);
      check("ld_done_fault", 8'(load_fault_out), 8'h0);

      // Timeout after 16 wait cycles
      req(1'b1, 3'b001, 1'b0, 5'd8, 1'b1);
      step();
      req(1'b0, 3'b000, 1'b0, 5'd0, 1'b0);
      check("to_w1_stall", 8'(stall_out), 8'h1);
      for (int i = 2; i <= 16; i++) begin
         step();
         check($sformatf("to_w%0d_stall", i), 8'(stall_out), 8'h1);
         check($sformatf("to_w%0d_fault", i), 8'(load_fault_out), 8'h0);
      end
      step();
      check("to_stall", 8'(stall_out), 8'h0);
      check("to_fault", 8'(load_fault_out), 8'h1);
      check("to_wr", 8'(rf_wr_en_out), 8'h0);
      step();
      check("to_fault_pulse", 8'(load_fault_out), 8'h0);

      // Valid on the 16th cycle beats the timeout
      req(1'b1, 3'b001, 1'b0, 5'd9, 1'b1);
      step();
      req(1'b0, 3'b000, 1'b0, 5'd0, 1'b0);
      for (int i = 2; i <= 16; i++) step();
      check("vt_w16_stall", 8'(stall_out), 8'h1);
      dmem_valid_in = 1'b1;
      step();
      dmem_valid_in = 1'b0;
      check("vt_wr", 8'(rf_wr_en_out), 8'h1);
      check("vt_fault", 8'(load_fault_out), 8'h0);
      check("vt_rd", 8'(rd_addr_reg_out), 8'd9);
      check("vt_stall", 8'(stall_out), 8'h0);

      // Flush with valid in WAIT_LOAD
      req(1'b1, 3'b001, 1'b1, 5'd10, 1'b1);
      step();
      req(1'b0, 3'b000, 1'b0, 5'd0, 1'b0);
      flush_in = 1'b1;
      dmem_valid_in = 1'b1;
      step();
      dmem_valid_in = 1'b0;
      check("fl_stall", 8'(stall_out), 8'h0);
      check("fl_wr", 8'(rf_wr_en_out), 8'h0);
      check("fl_fault", 8'(load_fault_out), 8'h0);
      // Flush in IDLE blocks acceptance
      req(1'b1, 3'b000, 1'b0, 5'd11, 1'b1);
      #1;
      check("fl_idle_ready", 8'(issue_ready_out), 8'h0);
      step();
      flush_in = 1'b0;
      check("fl_idle_wr", 8'(rf_wr_en_out), 8'h0);
      check("fl_idle_rd", 8'(rd_addr_reg_out), 8'd10);

      // Reserved select remap and rd=0 suppression
      req(1'b1, 3'b110, 1'b0, 5'd0, 1'b1);
      step();
      check("s110_sel", 8'(wb_mux_sel_reg_out), 8'h0);
      check("s110_wr", 8'(rf_wr_en_out), 8'h0);
      check("s110_rd", 8'(rd_addr_reg_out), 8'd0);
      req(1'b1, 3'b101, 1'b0, 5'd3, 1'b1);
      step();
      check("s101_sel", 8'(wb_mux_sel_reg_out), 8'h5);
      check("s101_wr", 8'(rf_wr_en_out), 8'h1);
      req(1'b1, 3'b111, 1'b1, 5'd4, 1'b0);
      step();
      check("s111_sel", 8'(wb_mux_sel_reg_out), 8'h0);
      check("s111_wr", 8'(rf_wr_en_out), 8'h0);

      // Reset during WAIT_LOAD
      req(1'b1, 3'b001, 1'b1, 5'd12, 1'b1);
      step();
      req(1'b0, 3'b000, 1'b0, 5'd0, 1'b0);
      step();
      check("rl_stall_pre", 8'(stall_out), 8'h1);
      rst_in = 1'b1;
      dmem_valid_in = 1'b1;
      step();
      dmem_valid_in = 1'b0;
      check("rl_stall", 8'(stall_out), 8'h0);
      check("rl_wr", 8'(rf_wr_en_out), 8'h0);
      check("rl_fault", 8'(load_fault_out), 8'h0);
      check("rl_sel", 8'(wb_mux_sel_reg_out), 8'h0);
      check("rl_alu", 8'(alu_src_reg_out), 8'h0);
      check("rl_rd", 8'(rd_addr_reg_out), 8'h0);
      check("rl_ready_in_rst", 8'(issue_ready_out), 8'h0);
      rst_in = 1'b0;
      #1;
      check("rl_ready", 8'(issue_ready_out), 8'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb_stage_controller.md
WB_STAGE_CONTROLLER -- requirements
Module: wb_stage_controller

Interface
REQ-001 The block SHALL have one clock and one reset: the reset is synchronous and active-high.
REQ-002 Parameter: LOAD_TIMEOUT, default 16, maximum number of WAIT_LOAD cycles before a load fault.
REQ-003 clk_in  input  1  rising-edge clock.
REQ-004 rst_in  input  1  synchronous active-high reset.
REQ-005 issue_valid_in  input  1  writeback request present this cycle.
REQ-006 issue_ready_out  output  1  request accepted when high with issue_valid_in.
REQ-007 wb_sel_in  input  3  requested writeback source: 000 ALU, 001 LU, 010 IMM, 011 IADDER, 101 PC+4.
REQ-008 alu_src_in  input  1  ALU second operand select (1 = rs2, 0 = imm).
REQ-009 rd_addr_in  input  5  destination register.
REQ-010 rf_wr_en_in  input  1  request writes the register file.
REQ-011 dmem_valid_in  input  1  load data valid from data memory.
REQ-012 flush_in  input  1  pipeline flush.
REQ-013 wb_mux_sel_reg_out  output  3  registered select to the writeback mux.
REQ-014 alu_src_reg_out  output  1  registered ALU second-source select.
REQ-015 rd_addr_reg_out  output  5  registered destination register.
REQ-016 rf_wr_en_out  output  1  register-file write strobe, one-cycle pulse per write.
REQ-017 stall_out  output  1  upstream pipeline hold.
REQ-018 load_fault_out  output  1  one-cycle pulse on load timeout.

Function
REQ-019 The FSM SHALL have two states: IDLE and WAIT_LOAD.
REQ-020 issue_ready_out SHALL be 1 only when state is IDLE, rst_in is 0 and flush_in is 0.
REQ-021 stall_out SHALL be 1 only when state is WAIT_LOAD, combinationally.
REQ-022 On acceptance (issue_valid_in & issue_ready_out), sel, alu_src and rd SHALL be registered to the *_reg_out outputs on the next edge.
REQ-023 Codes 100, 110 and 111 on wb_sel_in SHALL be registered as 000.
REQ-024 For an accepted non-LU request, rf_wr_en_out SHALL be 1 in the cycle after acceptance.
  - Condition: rf_wr_en_in=1 and rd_addr_in!=0.
  - State remains IDLE, giving one request per cycle throughput.
REQ-025 For an accepted LU request, the state SHALL go to WAIT_LOAD and rf_wr_en_out SHALL stay 0.
  - The wait counter clears to 0.
REQ-026 In WAIT_LOAD, if dmem_valid_in=1, the next cycle SHALL return to IDLE.
  - rf_wr_en_out pulses 1 if the captured wr_en=1 and rd!=0.
  - wb_mux_sel_reg_out holds 001.
REQ-027 In WAIT_LOAD without dmem_valid_in, the counter SHALL increment.
  - If the counter equals LOAD_TIMEOUT-1, the next cycle returns to IDLE.
  - load_fault_out pulses 1 for one cycle and no write occurs.
REQ-028 If dmem_valid_in and timeout coincide, valid SHALL win: write occurs, no fault.
REQ-029 flush_in in WAIT_LOAD SHALL return the block to IDLE next cycle with no write and no fault, regardless of dmem_valid_in.
REQ-030 flush_in in IDLE SHALL block acceptance that cycle.
REQ-031 dmem_valid_in SHALL be ignored in IDLE.
REQ-032 rd_addr_reg_out = 0 SHALL always force rf_wr_en_out to 0.
REQ-033 The counter SHALL be wide enough for LOAD_TIMEOUT-1 and SHALL never wrap.
REQ-034 *_reg_out outputs SHALL hold their last values while no request is accepted.

Reset
REQ-035 When rst_in is 1, on the clock edge the block SHALL enter IDLE with the counter at 0.
  - wb_mux_sel_reg_out=000, alu_src_reg_out=0, rd_addr_reg_out=0.
  - rf_wr_en_out=0, load_fault_out=0.
  - stall_out=0, and issue_ready_out=0 while rst_in is high.
REQ-036 Reset asserted in WAIT_LOAD SHALL abandon the load with no write and no fault.

Verification
REQ-037 Back-to-back ALU then IMM requests (rd=5, rd=6, wr_en=1) -> rf_wr_en_out=1 on two consecutive cycles.
  - Cycle 1: sel 000, rd 5. Cycle 2: sel 010, rd 6. stall_out stays 0.
REQ-038 LU request rd=7, dmem_valid_in on the 3rd WAIT_LOAD cycle -> stall_out=1 for 3 cycles.
  - Then rf_wr_en_out=1 with sel 001 and rd 7, and issue_ready_out=1.
REQ-039 LU request, no dmem_valid_in (LOAD_TIMEOUT=16) -> stall_out=1 for 16 cycles.
  - Then load_fault_out=1 for one cycle with rf_wr_en_out=0.
  - A valid arriving on the 16th cycle instead -> write, no fault.
REQ-040 LU request, then flush_in and dmem_valid_in in the same WAIT_LOAD cycle -> IDLE next cycle, rf_wr_en_out=0, load_fault_out=0.
REQ-041 Request sel 110, rd=0, wr_en=1 -> wb_mux_sel_reg_out=000, rf_wr_en_out=0.
REQ-042 rst_in asserted mid-WAIT_LOAD -> all outputs at reset values next cycle, and issue_ready_out=1 once rst_in deasserts.
